// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// SPI mode-0 master that sends SUMP-format commands and optionally reads a
// little-endian response of up to four bytes.
//
// A short command (opcode[7]=0) is the opcode byte alone. A long command
// (opcode[7]=1) is the opcode followed by data[7:0] .. data[31:24]. Every byte
// goes out MSB first. After the command, rx_count bytes (values above 4 are
// treated as 4) are clocked in from miso and presented on rsp_data with a
// single-cycle rsp_valid pulse when the transfer finishes.
//
// Ports
//   clock      : single clock, rising edge
//   extReset   : asynchronous active-low reset
//   cmd        : {data[31:0], opcode[7:0]}
//   cmd_valid  : request to send cmd (taken only while cmd_ready is high)
//   rx_count   : number of response bytes to read (0..4, larger values clamp)
//   cmd_ready  : idle and able to accept a command
//   rsp_data   : received bytes, first byte in [7:0], unused lanes zero
//   rsp_valid  : one-cycle pulse qualifying rsp_data
//   sclk       : SPI clock, idle low
//   cs         : active-low chip select
//   mosi       : serial data to the slave
//   miso       : serial data from the slave
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int HALF_PERIOD = 4,
    parameter int CS_SETUP    = 4,
    parameter int BYTE_GAP    = 8,
    parameter int CS_HOLD     = 4
) (
    input  logic        clock,
    input  logic        extReset,
    input  logic [39:0] cmd,
    input  logic        cmd_valid,
    input  logic [2:0]  rx_count,
    output logic        cmd_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_valid,
    output logic        sclk,
    output logic        cs,
    output logic        mosi,
    input  logic        miso
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_TX_BYTE,
        S_GAP,
        S_RX_BYTE,
        S_HOLD
    } state_t;

    // Terminal values of the timing counter for each timed phase.
    localparam logic [7:0] HP_LAST    = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] GAP_LAST   = 8'(BYTE_GAP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

    state_t      state;
    logic [7:0]  timer;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_cnt;
    logic [2:0]  tx_total;
    logic [2:0]  rx_total;
    logic        rx_phase;   // set once all command bytes are out
    logic [39:0] tx_data;    // remaining command bytes, next byte in [7:0]
    logic [7:0]  tx_sh;      // bits of the current byte still to be sent
    logic [7:0]  rx_sh;
    logic [31:0] rx_buf;

    // Response length saturates at four bytes.
    function automatic logic [2:0] sat_rx_count(input logic [2:0] n);
        return (n > 3'd4) ? 3'd4 : n;
    endfunction

    always_ff @(posedge clock or negedge extReset) begin
        if (!extReset) begin
            state     <= S_IDLE;
            cs        <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            timer     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            tx_total  <= '0;
            rx_total  <= '0;
            rx_phase  <= 1'b0;
            tx_data   <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            rx_buf    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= S_SETUP;
                        cs        <= 1'b0;
                        cmd_ready <= 1'b0;
                        timer     <= '0;
                        bit_cnt   <= '0;
                        byte_cnt  <= '0;
                        rx_phase  <= 1'b0;
                        tx_data   <= cmd;
                        tx_total  <= cmd[7] ? 3'd5 : 3'd1;
                        rx_total  <= sat_rx_count(rx_count);
                        rx_buf    <= '0;
                    end
                end

                S_SETUP: begin
                    if (timer == SETUP_LAST) begin
                        // First bit is presented while sclk is still low.
                        state   <= S_TX_BYTE;
                        timer   <= '0;
                        bit_cnt <= '0;
                        mosi    <= tx_data[7];
                        tx_sh   <= {tx_data[6:0], 1'b0};
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                S_GAP: begin
                    if (timer == GAP_LAST) begin
                        timer   <= '0;
                        bit_cnt <= '0;
                        if (rx_phase) begin
                            state <= S_RX_BYTE;
                        end else begin
                            state <= S_TX_BYTE;
                            mosi  <= tx_data[7];
                            tx_sh <= {tx_data[6:0], 1'b0};
                        end
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                S_TX_BYTE, S_RX_BYTE: begin
                    if (timer != HP_LAST) begin
                        timer <= timer + 8'd1;
                    end else begin
                        timer <= '0;
                        if (!sclk) begin
                            // Rising sclk: the slave's bit is captured on this edge.
                            sclk <= 1'b1;
                            if (state == S_RX_BYTE) begin
                                rx_sh <= {rx_sh[6:0], miso};
                            end
                        end else begin
                            // Falling sclk: next bit goes out, or the byte is done.
                            sclk <= 1'b0;
                            if (bit_cnt != 3'd7) begin
                                bit_cnt <= bit_cnt + 3'd1;
                                if (state == S_TX_BYTE) begin
                                    mosi  <= tx_sh[7];
                                    tx_sh <= {tx_sh[6:0], 1'b0};
                                end
                            end else begin
                                bit_cnt <= '0;
                                mosi    <= 1'b0;
                                if (state == S_TX_BYTE) begin
                                    tx_data <= {8'h00, tx_data[39:8]};
                                    if (byte_cnt == tx_total - 3'd1) begin
                                        byte_cnt <= '0;
                                        if (rx_total == 3'd0) begin
                                            state <= S_HOLD;
                                        end else begin
                                            rx_phase <= 1'b1;
                                            state    <= S_GAP;
                                        end
                                    end else begin
                                        byte_cnt <= byte_cnt + 3'd1;
                                        state    <= S_GAP;
                                    end
                                end else begin
                                    // Byte n of the response lands in lane n.
                                    rx_buf <= rx_buf | ({24'h0, rx_sh} << {byte_cnt, 3'b000});
                                    if (byte_cnt == rx_total - 3'd1) begin
                                        byte_cnt <= '0;
                                        state    <= S_HOLD;
                                    end else begin
                                        byte_cnt <= byte_cnt + 3'd1;
                                        state    <= S_GAP;
                                    end
                                end
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (timer == HOLD_LAST) begin
                        // Ready rises with cs so a waiting command is taken at once.
                        state     <= S_IDLE;
                        cs        <= 1'b1;
                        cmd_ready <= 1'b1;
                        timer     <= '0;
                        if (rx_total != 3'd0) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= rx_buf;
                        end
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Self-checking bench for spi_master with default parameters. A transaction
// model predicts cs/sclk/mosi/cmd_ready/rsp_valid/rsp_data for every cycle from
// the byte/bit timing rules; a slave model answers on miso. Directed cases pin
// known waveforms with literal values, then randomized commands follow.
// -----------------------------------------------------------------------------
module tb_spi_master;

    localparam int HP  = 4;
    localparam int CSS = 4;
    localparam int BG  = 8;
    localparam int CSH = 4;

    logic        clock = 1'b0;
    logic        extReset;
    logic [39:0] cmd;
    logic        cmd_valid;
    logic [2:0]  rx_count;
    logic        cmd_ready;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        sclk;
    logic        cs;
    logic        mosi;
    logic        miso = 1'b0;

    spi_master #(
        .HALF_PERIOD(HP),
        .CS_SETUP   (CSS),
        .BYTE_GAP   (BG),
        .CS_HOLD    (CSH)
    ) dut (
        .clock    (clock),
        .extReset (extReset),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .rx_count (rx_count),
        .cmd_ready(cmd_ready),
        .rsp_data (rsp_data),
        .rsp_valid(rsp_valid),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso)
    );

    always #5 clock = ~clock;

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    int tmo_req = 0;
    int tmo_seen = 0;
    int tid = 0;
    logic [7:0] tb_rsp [4];

    // ---------------- transaction model ----------------
    logic        m_in = 1'b0;
    int          m_k = 0;
    int          m_L = 0;
    int          m_ntx = 1;
    int          m_nrx = 0;
    logic [39:0] m_cmd = '0;
    logic [7:0]  m_srsp [4];
    logic [31:0] m_rsp = '0;

    always @(posedge clock) begin
        if (!extReset) begin
            m_in = 1'b0;
            m_k  = 0;
        end else if ((!m_in || m_k == m_L) && cmd_valid) begin
            m_in  = 1'b1;
            m_k   = 0;
            m_cmd = cmd;
            m_ntx = cmd[7] ? 5 : 1;
            m_nrx = (rx_count > 3'd4) ? 4 : int'(rx_count);
            m_L   = CSS + (m_ntx + m_nrx) * 16 * HP + (m_ntx + m_nrx - 1) * BG + CSH;
            m_rsp = '0;
            for (int b = 0; b < 4; b++) begin
                m_srsp[b] = tb_rsp[b];
                if (b < m_nrx) m_rsp[8*b +: 8] = tb_rsp[b];
            end
        end else if (m_in) begin
            if (m_k == m_L) m_in = 1'b0;
            else m_k = m_k + 1;
        end
    end

    function automatic logic [7:0] tx_byte(input int b);
        if (b == 0) return m_cmd[7:0];
        return m_cmd[8 + 8*(b-1) +: 8];
    endfunction

    // ---------------- slave ----------------
    int   s_rises = 0;
    logic s_prev = 1'b0;

    function automatic logic slave_bit(input int i);
        int j;
        if (i < m_ntx * 8) return 1'b1;
        j = i - m_ntx * 8;
        if (j / 8 >= 4) return 1'b0;
        return m_srsp[j/8][7 - (j % 8)];
    endfunction

    always @(negedge clock) begin
        if (cs) begin
            s_rises = 0;
            s_prev  = 1'b0;
            miso    = slave_bit(0);
        end else begin
            if (sclk && !s_prev) s_rises++;
            s_prev = sclk;
            if (!sclk) miso = slave_bit(s_rises);
        end
    end

    // ---------------- compare process ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    logic       cs_prev = 1'b1;
    logic       sclk_prev = 1'b0;
    int         low_cnt = 0;
    int         high_cnt = 0;
    int         last_gap = 0;
    int         rises = 0;
    int         dec_n = 0;
    logic [7:0] shb = '0;
    logic [7:0] dec [10];

    always @(negedge clock) begin
        logic e_cs, e_sclk, e_mosi, e_rdy, e_rv;
        int j, b, r;
        if (tmo_req != tmo_seen) begin
            chk("wait_bound", tmo_req, tmo_seen);
            tmo_seen = tmo_req;
        end
        if (!extReset) begin
            chk("rst_cs", cs, 1);
            chk("rst_sclk", sclk, 0);
            chk("rst_mosi", mosi, 0);
            chk("rst_ready", cmd_ready, 1);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            cs_prev = 1'b1; sclk_prev = 1'b0; low_cnt = 0; high_cnt = 0;
        end else begin
            e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_rdy = 1'b1; e_rv = 1'b0;
            if (m_in) begin
                if (m_k == m_L) begin
                    e_rv = (m_nrx > 0);
                end else begin
                    e_cs = 1'b0; e_rdy = 1'b0;
                    if (m_k >= CSS) begin
                        j = m_k - CSS;
                        b = j / (16*HP + BG);
                        r = j % (16*HP + BG);
                        if (b < m_ntx + m_nrx && r < 16*HP) begin
                            e_sclk = ((r % (2*HP)) >= HP);
                            if (b < m_ntx) e_mosi = tx_byte(b)[7 - r/(2*HP)];
                        end
                    end
                end
            end
            chk("cs", cs, e_cs);
            chk("sclk", sclk, e_sclk);
            chk("mosi", mosi, e_mosi);
            chk("cmd_ready", cmd_ready, e_rdy);
            chk("rsp_valid", rsp_valid, e_rv);
            if (e_rv) chk("rsp_data", rsp_data, m_rsp);

            // Waveform decode for the directed literal expectations.
            if (cs && !cs_prev) begin
                case (tid)
                    1: begin
                        chk("short_cs_low", low_cnt, CSS + 16*HP + CSH);
                        chk("short_rises", rises, 8);
                        chk("short_byte", dec[0], 8'h02);
                        chk("short_no_rsp", rsp_valid, 0);
                    end
                    2, 5: begin
                        chk("long_cs_low", low_cnt, 360);
                        chk("long_rises", rises, 40);
                        chk("long_nbytes", dec_n, 5);
                        chk("long_b0", dec[0], (tid == 2) ? 8'hC0 : 8'h81);
                        chk("long_b1", dec[1], (tid == 2) ? 8'h78 : 8'h0F);
                        chk("long_b2", dec[2], (tid == 2) ? 8'h56 : 8'h0F);
                        chk("long_b3", dec[3], (tid == 2) ? 8'h34 : 8'hA5);
                        chk("long_b4", dec[4], (tid == 2) ? 8'h12 : 8'hA5);
                    end
                    3: begin
                        chk("query_valid", rsp_valid, 1);
                        chk("query_data", rsp_data, 32'h534C_4131);
                        chk("query_rises", rises, 40);
                    end
                    4: begin
                        chk("clamp_rises", rises, 40);
                        chk("clamp_valid", rsp_valid, 1);
                    end
                    8: begin
                        chk("b2b_second_byte", dec[0], 8'h05);
                        chk("b2b_second_rises", rises, 8);
                    end
                    default: ;
                endcase
                high_cnt = 0;
            end
            if (!cs && cs_prev) begin
                last_gap = high_cnt;
                if (tid == 7) chk("b2b_cs_gap", last_gap, 1);
                low_cnt = 0; rises = 0; dec_n = 0;
            end
            if (!cs && sclk && !sclk_prev) begin
                shb = {shb[6:0], mosi};
                rises++;
                if (rises % 8 == 0 && dec_n < 10) begin
                    dec[dec_n] = shb;
                    dec_n++;
                end
            end
            if (cs) high_cnt++; else low_cnt++;
            cs_prev = cs;
            sclk_prev = sclk;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 3000) begin
            tick();
            n++;
        end
        if (!cmd_ready) tmo_req++;
    endtask

    task automatic send(input int t, input logic [39:0] c, input logic [2:0] rx,
                        input logic [31:0] rsp);
        wait_ready();
        tick();
        tid = t;
        for (int i = 0; i < 4; i++) tb_rsp[i] = rsp[8*i +: 8];
        cmd       = c;
        rx_count  = rx;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        extReset  = 1'b0;
        cmd       = '0;
        cmd_valid = 1'b0;
        rx_count  = '0;
        for (int i = 0; i < 4; i++) tb_rsp[i] = 8'h00;
        repeat (3) tick();
        extReset = 1'b1;
        tick();

        send(1, 40'h00_0000_0002, 3'd0, 32'h0);
        send(2, {32'h1234_5678, 8'hC0}, 3'd0, 32'h0);
        send(3, 40'h00_0000_0002, 3'd4, 32'h534C_4131);
        send(4, 40'h00_0000_0002, 3'd7, 32'hDEAD_BEEF);

        // Reset in the middle of the third byte of a long command.
        send(0, {32'hFFFF_FFFF, 8'hFF}, 3'd0, 32'h0);
        repeat (CSS + 2 * (16*HP + BG) + 20) tick();
        #2 extReset = 1'b0;
        repeat (3) tick();
        extReset = 1'b1;
        send(5, {32'hA5A5_0F0F, 8'h81}, 3'd0, 32'h0);

        // Back-to-back with cmd_valid held, then a dropped busy pulse.
        wait_ready();
        tick();
        tid = 6;
        for (int i = 0; i < 4; i++) tb_rsp[i] = 8'h00;
        cmd = 40'h00_0000_0003; rx_count = 3'd0; cmd_valid = 1'b1;
        tick();
        tick();
        tid = 7;
        cmd = 40'h00_0000_0005;
        wait_ready();
        tick();
        tick();
        tid = 8;
        cmd_valid = 1'b0;
        repeat (20) tick();
        cmd = 40'h00_0000_007F; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_ready();
        tick();
        tid = 0;

        // Randomized commands, some with stray requests while busy.
        for (int n = 0; n < 30; n++) begin
            send(0, {$urandom(), 8'($urandom())}, 3'($urandom_range(0, 7)), $urandom());
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 60)) tick();
                cmd = {$urandom(), 8'($urandom())};
                cmd_valid = 1'b1;
                tick();
                cmd_valid = 1'b0;
            end
            repeat ($urandom_range(0, 3)) tick();
        end

        wait_ready();
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
